// File: rtl/and4_stim_gen_if.sv
// Handshake and stimulus bundle between the and4 stimulus generator and its controller.
// The master drives start/stop and observes the channel outputs and run status.
interface and4_stim_gen_if #(
  parameter int CW = 8
);
  logic          i_start;
  logic          i_stop;
  logic          o_a;
  logic          o_b;
  logic          o_c;
  logic          o_d;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_tick_cnt;

  modport master (
    output i_start, i_stop,
    input  o_a, o_b, o_c, o_d, o_busy, o_done, o_tick_cnt
  );

  modport slave (
    input  i_start, i_stop,
    output o_a, o_b, o_c, o_d, o_busy, o_done, o_tick_cnt
  );
endinterface

// File: rtl/and4_stim_gen.sv
// Clocked four-channel square-wave stimulus for the 4-input gate stage.
// Each channel toggles every HP_x prescaled ticks; a run lasts RUN_TICKS ticks.
module and4_stim_gen #(
  parameter int DIV       = 1,
  parameter int HP_A      = 6,
  parameter int HP_B      = 10,
  parameter int HP_C      = 15,
  parameter int HP_D      = 20,
  parameter int RUN_TICKS = 100,
  parameter int CW        = 8
) (
  input logic            clk,
  input logic            rst,
  and4_stim_gen_if.slave bus
);
  localparam int PW = $clog2(DIV + 1);
  localparam int AW = $clog2(HP_A + 1);
  localparam int BW = $clog2(HP_B + 1);
  localparam int XW = $clog2(HP_C + 1);
  localparam int DW = $clog2(HP_D + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_a;
  logic          r_b;
  logic          r_c;
  logic          r_d;
  logic [CW-1:0] r_tick_cnt;
  logic [PW-1:0] r_psc;
  logic [AW-1:0] r_cnt_a;
  logic [BW-1:0] r_cnt_b;
  logic [XW-1:0] r_cnt_c;
  logic [DW-1:0] r_cnt_d;
  logic          w_tick;

  assign w_tick         = (r_psc == PW'(DIV - 1));
  assign bus.o_a        = r_a;
  assign bus.o_b        = r_b;
  assign bus.o_c        = r_c;
  assign bus.o_d        = r_d;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_tick_cnt = r_tick_cnt;

  // Run-control FSM with prescaler, channel counters and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_c        <= 1'b0;
      r_d        <= 1'b0;
      r_tick_cnt <= '0;
      r_psc      <= '0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_cnt_c    <= '0;
      r_cnt_d    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // stop has priority: start only takes effect when stop is low
          if (bus.i_start && !bus.i_stop) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_c        <= 1'b0;
            r_d        <= 1'b0;
            r_tick_cnt <= '0;
            r_psc      <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_cnt_c    <= '0;
            r_cnt_d    <= '0;
          end
        end
        S_RUN: begin
          if (bus.i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_psc      <= '0;
            r_tick_cnt <= r_tick_cnt + CW'(1);
            if (r_cnt_a == AW'(HP_A - 1)) begin
              r_cnt_a <= '0;
              r_a     <= ~r_a;
            end else begin
              r_cnt_a <= r_cnt_a + AW'(1);
            end
            if (r_cnt_b == BW'(HP_B - 1)) begin
              r_cnt_b <= '0;
              r_b     <= ~r_b;
            end else begin
              r_cnt_b <= r_cnt_b + BW'(1);
            end
            if (r_cnt_c == XW'(HP_C - 1)) begin
              r_cnt_c <= '0;
              r_c     <= ~r_c;
            end else begin
              r_cnt_c <= r_cnt_c + XW'(1);
            end
            if (r_cnt_d == DW'(HP_D - 1)) begin
              r_cnt_d <= '0;
              r_d     <= ~r_d;
            end else begin
              r_cnt_d <= r_cnt_d + DW'(1);
            end
            // the final tick still toggles and counts before entering DONE
            if (r_tick_cnt == CW'(RUN_TICKS - 1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_psc <= r_psc + PW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_and4_stim_gen.sv
// Self-checking bench: two generators (DIV=1 and DIV=3) share stimulus; a closed-form
// model pushes expected outputs per edge to a scoreboard that each test pops and checks.
module tb_and4_stim_gen;
  localparam int CW = 8;

  typedef struct packed {
    logic [16:0] v1;
    logic [16:0] v3;
  } exp_t;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst    = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;
  exp_t sb[$];
  int   m_st[2];
  int   m_ticks[2];
  int   m_psc[2];

  and4_stim_gen_if #(.CW(CW)) bus1 ();
  and4_stim_gen_if #(.CW(CW)) bus3 ();

  and4_stim_gen #(.DIV(1), .CW(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  and4_stim_gen #(.DIV(3), .CW(CW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 if (clk_en) clk = ~clk;

  function automatic logic [16:0] obs1();
    return {bus1.o_a, bus1.o_b, bus1.o_c, bus1.o_d, bus1.o_busy, bus1.o_done, bus1.o_tick_cnt};
  endfunction

  function automatic logic [16:0] obs3();
    return {bus3.o_a, bus3.o_b, bus3.o_c, bus3.o_d, bus3.o_busy, bus3.o_done, bus3.o_tick_cnt};
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Outputs after t ticks: channel x has toggled floor(t/HP_x) times.
  function automatic logic [16:0] m_exp(input int k);
    int t;
    t = m_ticks[k];
    return {1'((t / 6) % 2), 1'((t / 10) % 2), 1'((t / 15) % 2), 1'((t / 20) % 2),
            m_st[k] == 1, m_st[k] == 2, 8'(t)};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0;
      m_ticks[k] = 0;
      m_psc[k] = 0;
    end
    sb.delete();
  endtask

  task automatic m_step(input int k, input logic st, input logic sp);
    if (m_st[k] == 1) begin
      if (sp) m_st[k] = 0;
      else if (m_psc[k] == div_of(k) - 1) begin
        m_psc[k] = 0;
        m_ticks[k]++;
        if (m_ticks[k] == 100) m_st[k] = 2;
      end else m_psc[k]++;
    end else if (st && !sp) begin
      m_st[k] = 1;
      m_ticks[k] = 0;
      m_psc[k] = 0;
    end
  endtask

  task automatic cycle(input logic st, input logic sp);
    exp_t e;
    bus1.i_start = st;
    bus1.i_stop  = sp;
    bus3.i_start = st;
    bus3.i_stop  = sp;
    @(posedge clk);
    m_step(0, st, sp);
    m_step(1, st, sp);
    e.v1 = m_exp(0);
    e.v3 = m_exp(1);
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    n_chk++;
    if (obs1() !== 17'h0 || obs3() !== 17'h0) begin
      n_err++;
      $display("FAIL reset_init got %h/%h want 0", obs1(), obs3());
    end
    for (int k = 0; k < 16; k++) begin
      cycle(k == 0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL pre_reset k=%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
    end
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs1() !== 17'h0 || obs3() !== 17'h0) begin
      n_err++;
      $display("FAIL async_reset got %h/%h want 0", obs1(), obs3());
    end
    #1 rst = 1'b0;
    m_reset();
    #1 clk_en = 1'b1;
  endtask

  task automatic test_full_run();
    exp_t e;
    logic [3:0] want;
    cycle(1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (obs1() !== e.v1 || obs3() !== e.v3 || bus1.o_busy !== 1'b1 || bus3.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL run_start got %h/%h want %h/%h", obs1(), obs3(), e.v1, e.v3);
    end
    for (int k = 1; k <= 300; k++) begin
      cycle(1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL full_run E%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
      if (k == 6 || k == 10 || k == 12 || k == 15 || k == 20) begin
        want = (k == 6) ? 4'b1000 : (k == 10) ? 4'b1100 : (k == 12) ? 4'b0100 :
               (k == 15) ? 4'b0110 : 4'b1011;
        n_chk++;
        if ({bus1.o_a, bus1.o_b, bus1.o_c, bus1.o_d} !== want) begin
          n_err++;
          $display("FAIL edges_div1 E%0d got abcd=%b want %b", k, {bus1.o_a, bus1.o_b, bus1.o_c, bus1.o_d}, want);
        end
      end
      if (k == 100) begin
        n_chk++;
        if (obs1() !== {4'b0001, 1'b0, 1'b1, 8'd100}) begin
          n_err++;
          $display("FAIL end_div1 got %h want %h", obs1(), {4'b0001, 1'b0, 1'b1, 8'd100});
        end
      end
      if ((k == 6 && bus3.o_tick_cnt !== 8'd2) || (k == 17 && bus3.o_a !== 1'b0) ||
          (k == 18 && bus3.o_a !== 1'b1) || (k == 299 && bus3.o_done !== 1'b0)) begin
        n_err++;
        $display("FAIL prescale E%0d got tick=%0d a=%b done=%b", k, bus3.o_tick_cnt, bus3.o_a, bus3.o_done);
      end
      if (k == 6 || k == 17 || k == 18 || k == 299) n_chk++;
      if (k == 300) begin
        n_chk++;
        if (obs3() !== {4'b0001, 1'b0, 1'b1, 8'd100}) begin
          n_err++;
          $display("FAIL end_div3 got %h want %h", obs3(), {4'b0001, 1'b0, 1'b1, 8'd100});
        end
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    for (int k = 0; k <= 18; k++) begin
      cycle(k == 0, k == 13);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL abort E%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
      if (k >= 13) begin
        n_chk++;
        if (obs1() !== {4'b0100, 1'b0, 1'b0, 8'd12}) begin
          n_err++;
          $display("FAIL abort_hold E%0d got %h want %h", k, obs1(), {4'b0100, 1'b0, 1'b0, 8'd12});
        end
      end
    end
    for (int k = 0; k <= 100; k++) begin
      cycle(k == 0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL rerun E%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
      if (k == 0 || k == 6) begin
        n_chk++;
        if (obs1() !== ((k == 0) ? {4'b0000, 1'b1, 1'b0, 8'd0} : {4'b1000, 1'b1, 1'b0, 8'd6})) begin
          n_err++;
          $display("FAIL rerun_timing E%0d got %h", k, obs1());
        end
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    for (int k = 0; k <= 102; k++) begin
      // k0: stop only; k1: start+stop; k2: start; k52: start during RUN
      cycle(k == 1 || k == 2 || k == 52, k == 0 || k == 1);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL priority k=%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
      if (k == 1) begin
        n_chk++;
        if (bus1.o_done !== 1'b1 || bus1.o_tick_cnt !== 8'd100 || bus3.o_busy !== 1'b0 || bus3.o_done !== 1'b0) begin
          n_err++;
          $display("FAIL start_stop_both got %h/%h", obs1(), obs3());
        end
      end
      if (k == 53) begin
        n_chk++;
        if (bus1.o_tick_cnt !== 8'd51 || bus1.o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_in_run got tick=%0d want 51", bus1.o_tick_cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k <= 230; k++) begin
      cycle(k == 210, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (obs1() !== e.v1 || obs3() !== e.v3) begin
        n_err++;
        $display("FAIL restart k=%0d got %h/%h want %h/%h", k, obs1(), obs3(), e.v1, e.v3);
      end
      if (k == 209 || k == 210) begin
        n_chk++;
        if (obs3() !== ((k == 209) ? {4'b0001, 1'b0, 1'b1, 8'd100} : {4'b0000, 1'b1, 1'b0, 8'd0})) begin
          n_err++;
          $display("FAIL restart_done k=%0d got %h", k, obs3());
        end
      end
      if (k == 216 || k == 228) begin
        n_chk++;
        if (bus1.o_a !== 1'b1 || bus3.o_a !== (k == 228)) begin
          n_err++;
          $display("FAIL restart_timing k=%0d got a1=%b a3=%b", k, bus1.o_a, bus3.o_a);
        end
      end
    end
  endtask

  initial begin
    bus1.i_start = 1'b0;
    bus1.i_stop  = 1'b0;
    bus3.i_start = 1'b0;
    bus3.i_stop  = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_full_run();
    test_abort();
    test_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/and4_stim_gen.md
Name: and4_stim_gen

Overview:
- Synchronous stimulus generator that sits directly upstream of the 4-input gate stage and drives its a/b/c/d inputs.
- Each of four channels toggles at its own programmable half-period, measured in prescaled ticks.
- Runs for a fixed number of ticks, then stops and flags completion.
- Replaces free-running delay-based toggling with a clocked, repeatable pattern for on-board and simulation use.

Parameters:
- DIV, 1: clock cycles per tick (prescaler); legal values >= 1.
- HP_A, 6: half-period of channel a, in ticks; legal values >= 1.
- HP_B, 10: half-period of channel b, in ticks.
- HP_C, 15: half-period of channel c, in ticks.
- HP_D, 20: half-period of channel d, in ticks.
- RUN_TICKS, 100: run length in ticks; legal values >= 1.
- CW, 8: width of tick_cnt; must satisfy 2^CW > RUN_TICKS.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: level sampled each clock; begins a run.
- stop, input, 1: level sampled each clock; aborts a run.
- a, output, 1: channel a stimulus (registered).
- b, output, 1: channel b stimulus (registered).
- c, output, 1: channel c stimulus (registered).
- d, output, 1: channel d stimulus (registered).
- busy, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- tick_cnt, output, CW: number of ticks elapsed in the current or last run.

Behaviour:
- Reset (async, rst=1): state=IDLE; a=b=c=d=0; busy=0; done=0; tick_cnt=0; prescaler and all channel counters = 0. Deassertion takes effect at the next clock edge.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), both registered/decoded with no combinational path from inputs.
- IDLE or DONE, with start=1 and stop=0 at an edge:
  - a..d, tick_cnt, prescaler and channel counters all clear to 0.
  - Next state is RUN.
- RUN, prescaler:
  - Counts 0..DIV-1.
  - A tick occurs on an edge where prescaler==DIV-1; the prescaler then wraps to 0.
  - With DIV=1, every edge in RUN is a tick.
- RUN, per tick:
  - tick_cnt increments.
  - Each channel counter increments. When a counter equals HP_x-1 it wraps to 0 and its output inverts on that same edge.
  - Channels are independent; coincident toggles all apply on the same edge.
- RUN, end of run: on the tick where tick_cnt==RUN_TICKS-1, that tick's toggles and increment still apply (tick_cnt becomes RUN_TICKS) and next state is DONE.
- DONE: outputs, tick_cnt and counters hold. done stays high until a new start.
- stop=1 in RUN: next state is IDLE. Outputs and tick_cnt hold; no toggle or increment on that edge, even if it would have been a tick.
- start and stop both 1: stop wins in every state (RUN goes to IDLE; IDLE and DONE stay put).
- start while in RUN: ignored (no restart).
- rst during RUN: immediate return to reset values, no completion flag.
- Output latency: each toggle appears on the clock edge of its tick, with zero extra pipeline stages.

Test Plan:
- Reset check: assert rst mid-cycle with clk stopped -> a=b=c=d=0, busy=0, done=0, tick_cnt=0 immediately.
- Full run (defaults, DIV=1): start=1 for one cycle (edge E0).
  - busy=1 after E0.
  - a rises at E6, falls at E12; b rises at E10; c at E15; d at E20.
  - After E100: done=1, busy=0, tick_cnt=100, a=0, b=0, c=0, d=1.
- Prescale: DIV=3, start at E0 -> a first toggles at E18, tick_cnt=2 after E6, done after E300.
- Abort: stop=1 at E13 (DIV=1) -> state IDLE after E13; a=0 and b=1 hold, tick_cnt=12 holds, done stays 0. A later start clears everything and reproduces the full-run timing.
- Priority: start=stop=1 in IDLE -> stays IDLE. start=1 during RUN at E50 -> no restart, tick_cnt continues to 100.
- Restart from DONE: start after completion -> outputs clear to 0, done=0 and busy=1 on the next edge, and the toggle timing repeats exactly.
